// File: rtl/vga_scanout.sv
// Framebuffer scan-out: generates 640x480@60 VGA timing at a 25 MHz pixel rate from the
// 50 MHz clock, fetches each 160x120 framebuffer word and draws it as a 4x4 block.
module vga_scanout #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned FB_WIDTH    = 160,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        frame_start
);

  localparam logic [9:0] H_ACT_END = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_VISIBLE);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic        pix_en_q, vga_clk_q;
  logic [9:0]  h_cnt_q, v_cnt_q, h_cnt_d, v_cnt_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        active1_q, hs1_q, vs1_q, first1_q;
  logic        blank_n_q, hs_q, vs_q, frame_start_q;
  logic [9:0]  r_q, g_q, b_q;
  logic        active0, hs0, vs0, first0;
  logic [9:0]  fb_x, fb_y;
  logic [9:0]  chan_d [3];

  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    active0 = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hs0     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs0     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    first0  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    fb_x    = h_cnt_q >> SCALE_SHIFT;
    fb_y    = v_cnt_q >> SCALE_SHIFT;
    // Address only follows the beam while visible; blanking reads are don't-care.
    rd_addr_d = rd_addr_q;
    if (active0) begin
      rd_addr_d = 15'(fb_y) * 15'(FB_WIDTH) + 15'(fb_x);
    end
  end

  // Each colour bit drives its whole 10-bit DAC channel; index 0/1/2 = R/G/B.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign chan_d[gi] = active1_q ? {10{rd_data[2-gi]}} : 10'd0;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rd_addr_q     <= '0;
      active1_q     <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      first1_q      <= 1'b0;
      blank_n_q     <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      vga_clk_q     <= ~pix_en_q;
      frame_start_q <= 1'b0;
      if (pix_en_q) begin
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        rd_addr_q     <= rd_addr_d;
        active1_q     <= active0;
        hs1_q         <= hs0;
        vs1_q         <= vs0;
        first1_q      <= first0;
        r_q           <= chan_d[0];
        g_q           <= chan_d[1];
        b_q           <= chan_d[2];
        blank_n_q     <= active1_q;
        hs_q          <= hs1_q;
        vs_q          <= vs1_q;
        frame_start_q <= first1_q;
      end
    end
  end

  assign rd_addr     = rd_addr_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scan-out bench: random framebuffer contents, random data on don't-care fetch slots, every
// clock compared with a pixel-index reference model. Vertical timing is shortened to fit runtime.
module tb_vga_scanout;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 16, VF = 2, VS = 2, VB = 4;
  localparam int FBW = 160, SH = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int FB_SIZE = 19200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data = 3'd0;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [9:0]  VGA_R, VGA_G, VGA_B;

  logic [2:0]  fb [FB_SIZE];
  int total = 0;
  int bad = 0;
  int fs_seen = 0;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FB_WIDTH(FBW), .SCALE_SHIFT(SH)
  ) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic pix_active(input int p);
    return ((p % HT) < HV) && ((p / HT) < VV);
  endfunction

  function automatic logic [14:0] pix_addr(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return 15'((v >> SH) * FBW + (h >> SH));
  endfunction

  function automatic logic [35:0] pins_now();
    return {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start, VGA_R, VGA_G, VGA_B};
  endfunction

  // Expected pins after the k-th clock edge following reset release (k=0: in reset).
  // Pixel n is on the pins from edge 4+2n; pixel index p = n mod FRAME gives (h,v).
  function automatic logic [35:0] exp_pins(input int k);
    logic vclk, hs, vs, act, fs;
    logic [2:0] c;
    int n, p, h, v;
    vclk = (k % 2) == 1;
    if (k < 4) return {vclk, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0};
    n   = (k - 4) / 2;
    p   = n % FRAME;
    h   = p % HT;
    v   = p / HT;
    act = pix_active(p);
    hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    fs  = ((k % 2) == 0) && (p == 0);
    c   = act ? fb[pix_addr(p)] : 3'd0;
    return {vclk, hs, vs, act, 1'b0, fs, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
  endfunction

  // Runs n_clk edges after a reset release, checking every edge and acting as the memory.
  task automatic run_model(input int n_clk);
    logic [14:0] exp_addr;
    logic [14:0] addr_prev;
    int m;
    exp_addr  = '0;
    addr_prev = '0;
    for (int k = 1; k <= n_clk; k++) begin
      @(posedge clk);
      #1;
      if ((k % 2) == 0) begin
        m = ((k - 2) / 2) % FRAME;
        if (pix_active(m)) exp_addr = pix_addr(m);
      end
      check_eq($sformatf("pins k=%0d", k), 64'(pins_now()), 64'(exp_pins(k)));
      check_eq($sformatf("addr k=%0d", k), 64'(rd_addr), 64'(exp_addr));
      if (frame_start) fs_seen++;
      // Real data only where the next pixel-rate edge samples a visible pixel.
      if ((k % 2) == 1 && k + 1 >= 4 && pix_active(((k - 3) / 2) % FRAME))
        rd_data = (int'(addr_prev) < FB_SIZE) ? fb[addr_prev] : 3'd0;
      else
        rd_data = 3'($urandom);
      addr_prev = rd_addr;
    end
  endtask

  initial begin
    for (int i = 0; i < FB_SIZE; i++) fb[i] = 3'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset pins", 64'(pins_now()), 64'(exp_pins(0)));
    check_eq("reset addr", 64'(rd_addr), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // One full frame, the wrap, then up to h=300, v=10 of the second frame.
    fs_seen = 0;
    run_model(4 + 2 * (FRAME + 10 * HT + 300));
    check_eq("frame_start count run1", 64'(fs_seen), 64'd2);

    resetn = 1'b0;
    #2;
    check_eq("async reset pins", 64'(pins_now()), 64'(exp_pins(0)));
    check_eq("async reset addr", 64'(rd_addr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("reset hold pins %0d", i), 64'(pins_now()), 64'(exp_pins(0)));
      check_eq($sformatf("reset hold addr %0d", i), 64'(rd_addr), 64'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    fs_seen = 0;
    run_model(3000);
    check_eq("frame_start count run2", 64'(fs_seen), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
